// File: rtl/pc_jump_ctrl.sv
// Fetch PC update: sequential advance, jump redirect, and a one-deep buffer for a jump resolved under stall.
// Redirect PC appears one edge after the accepting cycle; stall holds the PC and defers any buffered redirect.
module pc_jump_ctrl #(
  parameter int                  PC_WIDTH  = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
  parameter int                  INST_STEP = 1,
  parameter int                  CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 jump_valid,
  input  logic                 jump_en,
  input  logic [PC_WIDTH-1:0]  jump_target,
  input  logic                 stall,
  output logic [PC_WIDTH-1:0]  pc,
  output logic                 flush_if,
  output logic                 jump_pending,
  output logic [CNT_WIDTH-1:0] jump_cnt
);

  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_e;

  localparam logic [PC_WIDTH-1:0] STEP = PC_WIDTH'(INST_STEP);

  state_e                state_q;
  logic [PC_WIDTH-1:0]   pc_q;
  logic [PC_WIDTH-1:0]   tgt_q;
  logic [CNT_WIDTH-1:0]  cnt_q;

  logic                  taken;
  logic                  redirect;
  logic [CNT_WIDTH-1:0]  cnt_d;

  always_comb begin
    taken    = jump_valid & jump_en;
    redirect = ~stall & (((state_q == IDLE) & taken) | (state_q == PEND));
    cnt_d    = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);
  end

  // While PEND, decode re-presents the same jump, so its inputs are ignored
  // and the buffered target is the only source of the redirect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      tgt_q   <= '0;
      cnt_q   <= '0;
    end else if (state_q == IDLE) begin
      if (!stall) begin
        if (taken) begin
          pc_q  <= jump_target;
          cnt_q <= cnt_d;
        end else begin
          pc_q  <= pc_q + STEP;
        end
      end else if (taken) begin
        tgt_q   <= jump_target;
        state_q <= PEND;
      end
    end else begin
      if (!stall) begin
        pc_q    <= tgt_q;
        cnt_q   <= cnt_d;
        state_q <= IDLE;
      end
    end
  end

  assign pc           = pc_q;
  assign jump_pending = (state_q == PEND);
  assign jump_cnt     = cnt_q;
  assign flush_if     = redirect & rst;

endmodule

// File: tb/tb_pc_jump_ctrl.sv
// Directed bench for pc_jump_ctrl with a reference model feeding an expected-state queue.
// A second instance with a 4-bit counter exercises counter saturation in few cycles.
module tb_pc_jump_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        jv, je, stall;
  logic [15:0] tgt;

  logic [15:0] pc, pc_s;
  logic        flush, flush_s, pend, pend_s;
  logic [15:0] cnt;
  logic [3:0]  cnt_s;

  always #5 clk = ~clk;

  pc_jump_ctrl #(.PC_WIDTH(16), .RESET_PC(16'h0000), .INST_STEP(1), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .jump_valid(jv), .jump_en(je), .jump_target(tgt), .stall(stall),
    .pc(pc), .flush_if(flush), .jump_pending(pend), .jump_cnt(cnt)
  );

  pc_jump_ctrl #(.PC_WIDTH(16), .RESET_PC(16'h0000), .INST_STEP(1), .CNT_WIDTH(4)) dut_s (
    .clk(clk), .rst(rst), .jump_valid(jv), .jump_en(je), .jump_target(tgt), .stall(stall),
    .pc(pc_s), .flush_if(flush_s), .jump_pending(pend_s), .jump_cnt(cnt_s)
  );

  typedef struct packed {
    logic [15:0] pc;
    logic        pend;
    logic [15:0] cnt;
    logic [3:0]  cnt_s;
  } exp_t;

  exp_t q[$];
  int checks   = 0;
  int failures = 0;

  logic [15:0] m_pc, m_tgt, m_cnt;
  logic        m_pend;
  logic [3:0]  m_cnt_s;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_pc = 16'h0000; m_tgt = 16'h0000; m_cnt = 16'h0000; m_pend = 1'b0; m_cnt_s = 4'h0;
  endtask

  task automatic model_inc();
    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    if (m_cnt_s != 4'hF) m_cnt_s = m_cnt_s + 4'd1;
  endtask

  // Called just after a rising edge; drives one cycle and checks its outcome.
  task automatic step(input logic v, input logic e, input logic s, input logic [15:0] t);
    logic taken, exp_flush;
    exp_t got;
    jv = v; je = e; stall = s; tgt = t;
    @(negedge clk);
    taken     = v & e;
    exp_flush = ~s & ((~m_pend & taken) | m_pend);
    chk("flush_if", {31'd0, flush}, {31'd0, exp_flush});
    chk("flush_if_s", {31'd0, flush_s}, {31'd0, exp_flush});
    if (!m_pend) begin
      if (!s) begin
        if (taken) begin m_pc = t; model_inc(); end
        else m_pc = m_pc + 16'd1;
      end else if (taken) begin
        m_pend = 1'b1; m_tgt = t;
      end
    end else if (!s) begin
      m_pc = m_tgt; m_pend = 1'b0; model_inc();
    end
    q.push_back('{pc: m_pc, pend: m_pend, cnt: m_cnt, cnt_s: m_cnt_s});
    @(posedge clk);
    #1;
    got = q.pop_front();
    chk("pc", {16'd0, pc}, {16'd0, got.pc});
    chk("jump_pending", {31'd0, pend}, {31'd0, got.pend});
    chk("jump_cnt", {16'd0, cnt}, {16'd0, got.cnt});
    chk("jump_cnt_sat4", {28'd0, cnt_s}, {28'd0, got.cnt_s});
  endtask

  initial begin
    rst = 1'b0; jv = 1'b1; je = 1'b1; stall = 1'b0; tgt = 16'h0055;
    model_reset();
    #12;
    chk("reset_pc", {16'd0, pc}, 32'h0);
    chk("reset_pend", {31'd0, pend}, 32'h0);
    chk("reset_cnt", {16'd0, cnt}, 32'h0);
    chk("reset_flush", {31'd0, flush}, 32'h0);
    jv = 1'b0; je = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;

    // Sequential advance from reset
    repeat (5) step(1'b0, 1'b0, 1'b0, 16'h0000);
    // Taken jump with no stall
    step(1'b1, 1'b1, 1'b0, 16'h0040);
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    // Jump resolved under stall; target changes while pending
    step(1'b1, 1'b1, 1'b0, 16'h0010);
    step(1'b1, 1'b1, 1'b1, 16'h0080);
    step(1'b1, 1'b1, 1'b1, 16'h0099);
    step(1'b1, 1'b1, 1'b1, 16'h0099);
    step(1'b1, 1'b1, 1'b0, 16'h0099);
    chk("pend_release_pc", {16'd0, pc}, 32'h0080);
    // Not-taken resolution
    step(1'b1, 1'b1, 1'b0, 16'h0020);
    step(1'b1, 1'b0, 1'b0, 16'h0123);
    chk("not_taken_pc", {16'd0, pc}, 32'h0021);
    // PC wrap
    step(1'b1, 1'b1, 1'b0, 16'hFFFF);
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    chk("wrap_pc", {16'd0, pc}, 32'h0000);
    // Stall with no jump holds
    step(1'b0, 1'b0, 1'b1, 16'h0000);
    // Drive the small counter into saturation and beyond
    for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, 16'(16'h0100 + i));
    chk("cnt_sat4", {28'd0, cnt_s}, 32'hF);

    // Reset while a jump is pending
    step(1'b1, 1'b1, 1'b0, 16'h0030);
    step(1'b1, 1'b1, 1'b1, 16'h0080);
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("midreset_pc", {16'd0, pc}, 32'h0);
    chk("midreset_pend", {31'd0, pend}, 32'h0);
    chk("midreset_cnt", {16'd0, cnt}, 32'h0);
    chk("midreset_flush", {31'd0, flush}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;
    step(1'b0, 1'b0, 1'b1, 16'h0000);
    step(1'b0, 1'b0, 1'b0, 16'h0000);
    chk("post_reset_pc", {16'd0, pc}, 32'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
